// File: rtl/switch_debounce.sv
// switch_debounce: per-bit two-flop synchronizer and mismatch-count debouncer
// for raw DIP switch lines, producing a clean level bus plus one-cycle
// rise/fall strobes. Every bit is independent; bits accepted on the same
// edge update together.
module switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_rise,
  output logic [WIDTH-1:0] s_fall
);

  // A single-cycle debounce still needs a 1-bit counter to keep the
  // declarations legal; it simply never leaves zero.
  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] s_next;

  // Two-flop synchronizer; only sync2 is allowed to feed logic.
  // NOTE: every clocked block uses <= so all flops sample pre-edge values;
  // a blocking = here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce decision: count consecutive mismatches, accept the new
  // level on the last one, and clear on any match.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; without them
    // the bits left untouched by the if/else chain would infer latches.
    s_next = s;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (sync2[i] == s[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        s_next[i]   = sync2[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + 1'b1;
      end
    end
  end

  // Debounced level, counters and edge strobes; strobes are registered on the
  // same edge as the level so they coincide with the new value of s.
  always_ff @(posedge clk) begin
    if (reset) begin
      s      <= '0;
      s_rise <= '0;
      s_fall <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset element by element; this discards any in-progress count.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s      <= s_next;
      s_rise <= s_next & ~s;
      s_fall <= ~s_next & s;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed scenarios plus randomized switch activity on
// two instances (DEBOUNCE_CYCLES = 4 and 1), compared against a history-
// window reference model: a level is accepted once the last D synchronized
// samples all differ from the current debounced level.
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw4, s4, r4, f4;
  logic [3:0] sw1, s1, r1, f1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  switch_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw4),
    .s      (s4),
    .s_rise (r4),
    .s_fall (f4)
  );

  switch_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw1),
    .s      (s1),
    .s_rise (r1),
    .s_fall (f1)
  );

  // Reference model. h[0] holds the raw value sampled at the previous edge,
  // so the synchronized value in force at the current edge is h[1], and the
  // last D synchronized samples are h[1..D]. Reset clears the history.
  logic [3:0] h4 [0:4];
  logic [3:0] h1 [0:1];
  logic [3:0] m4_s, m4_r, m4_f;
  logic [3:0] m1_s, m1_r, m1_f;

  always @(posedge clk) begin : model4
    logic [3:0] diff, ns;
    if (reset) begin
      m4_s <= '0; m4_r <= '0; m4_f <= '0;
      for (int j = 0; j <= 4; j++) h4[j] <= '0;
    end else begin
      diff = 4'hf;
      for (int j = 1; j <= 4; j++) diff = diff & (h4[j] ^ m4_s);
      ns = m4_s ^ diff;
      m4_r <= ns & ~m4_s;
      m4_f <= ~ns & m4_s;
      m4_s <= ns;
      h4[0] <= sw4;
      for (int j = 1; j <= 4; j++) h4[j] <= h4[j-1];
    end
  end

  always @(posedge clk) begin : model1
    logic [3:0] ns;
    if (reset) begin
      m1_s <= '0; m1_r <= '0; m1_f <= '0;
      h1[0] <= '0; h1[1] <= '0;
    end else begin
      ns = m1_s ^ (h1[1] ^ m1_s);
      m1_r <= ns & ~m1_s;
      m1_f <= ~ns & m1_s;
      m1_s <= ns;
      h1[0] <= sw1;
      h1[1] <= h1[0];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sw4   = '0;
    sw1   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sw4   = 4'b1111;
    sw1   = 4'b0000;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if ({s4, r4, f4} !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold edge %0d: s/rise/fall=%b/%b/%b required 0000/0000/0000", e, s4, r4, f4);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      logic [3:0] es, er;
      step();
      es = (e >= 6) ? 4'b1111 : 4'b0000;
      er = (e == 6) ? 4'b1111 : 4'b0000;
      checks++;
      if (s4 !== es || r4 !== er || f4 !== 4'b0000) begin
        errors++;
        $display("FAIL power_up edge %0d: s/rise/fall=%b/%b/%b required %b/%b/0000", e, s4, r4, f4, es, er);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    step();
    sw4[0] = 1'b1;
    step(); step(); step();
    sw4[0] = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if ({s4, r4, f4} !== 12'h000) begin
        errors++;
        $display("FAIL glitch cycle %0d: s/rise/fall=%b/%b/%b required 0000/0000/0000", e, s4, r4, f4);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pattern;
    pattern = 5'b10101;
    apply_reset();
    step();
    for (int k = 4; k >= 1; k--) begin
      sw4[2] = pattern[k];
      step();
      checks++;
      if ({s4, r4, f4} !== 12'h000) begin
        errors++;
        $display("FAIL bounce_early: s/rise/fall=%b/%b/%b required 0000/0000/0000", s4, r4, f4);
      end
    end
    sw4[2] = pattern[0];
    for (int e = 1; e <= 7; e++) begin
      logic [3:0] es, er;
      step();
      es = (e >= 6) ? 4'b0100 : 4'b0000;
      er = (e == 6) ? 4'b0100 : 4'b0000;
      checks++;
      if (s4 !== es || r4 !== er || f4 !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_settle edge %0d: s/rise/fall=%b/%b/%b required %b/%b/0000", e, s4, r4, f4, es, er);
      end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    sw4 = 4'b1010;
    for (int e = 1; e <= 6; e++) begin
      logic [3:0] es, er;
      step();
      es = (e == 6) ? 4'b1010 : 4'b0000;
      er = es;
      checks++;
      if (s4 !== es || r4 !== er || f4 !== 4'b0000) begin
        errors++;
        $display("FAIL multi_rise edge %0d: s/rise/fall=%b/%b/%b required %b/%b/0000", e, s4, r4, f4, es, er);
      end
    end
    sw4 = 4'b0101;
    for (int e = 1; e <= 6; e++) begin
      logic [3:0] es, er, ef;
      step();
      es = (e == 6) ? 4'b0101 : 4'b1010;
      er = (e == 6) ? 4'b0101 : 4'b0000;
      ef = (e == 6) ? 4'b1010 : 4'b0000;
      checks++;
      if (s4 !== es || r4 !== er || f4 !== ef) begin
        errors++;
        $display("FAIL multi_mixed edge %0d: s/rise/fall=%b/%b/%b required %b/%b/%b", e, s4, r4, f4, es, er, ef);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    apply_reset();
    sw4[1] = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({s4, r4, f4} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: s/rise/fall=%b/%b/%b required 0000/0000/0000", s4, r4, f4);
    end
    for (int e = 1; e <= 6; e++) begin
      logic [3:0] es;
      step();
      es = (e == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (s4 !== es || r4 !== es || f4 !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_recover edge %0d: s/rise/fall=%b/%b/%b required %b/%b/0000", e, s4, r4, f4, es, es);
      end
    end
  endtask

  task automatic test_min_param();
    apply_reset();
    sw1[3] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      logic [3:0] es, er;
      step();
      es = (e >= 3) ? 4'b1000 : 4'b0000;
      er = (e == 3) ? 4'b1000 : 4'b0000;
      checks++;
      if (s1 !== es || r1 !== er || f1 !== 4'b0000) begin
        errors++;
        $display("FAIL min_step edge %0d: s/rise/fall=%b/%b/%b required %b/%b/0000", e, s1, r1, f1, es, er);
      end
    end
    sw1[3] = 1'b0;
    step(); step(); step(); step();
    sw1[3] = 1'b1;
    step();
    sw1[3] = 1'b0;
    for (int e = 2; e <= 5; e++) begin
      logic [3:0] es, er, ef;
      step();
      es = (e == 3) ? 4'b1000 : 4'b0000;
      er = (e == 3) ? 4'b1000 : 4'b0000;
      ef = (e == 4) ? 4'b1000 : 4'b0000;
      checks++;
      if (s1 !== es || r1 !== er || f1 !== ef) begin
        errors++;
        $display("FAIL min_pulse edge %0d: s/rise/fall=%b/%b/%b required %b/%b/%b", e, s1, r1, f1, es, er, ef);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) sw4[b] = ~sw4[b];
        if ($urandom_range(0, 2) == 0) sw1[b] = ~sw1[b];
      end
      step();
      checks++;
      if ({s4, r4, f4} !== {m4_s, m4_r, m4_f}) begin
        errors++;
        $display("FAIL random_d4 cycle %0d: s/rise/fall=%b/%b/%b required %b/%b/%b", n, s4, r4, f4, m4_s, m4_r, m4_f);
      end
      checks++;
      if ({s1, r1, f1} !== {m1_s, m1_r, m1_f}) begin
        errors++;
        $display("FAIL random_d1 cycle %0d: s/rise/fall=%b/%b/%b required %b/%b/%b", n, s1, r1, f1, m1_s, m1_r, m1_f);
      end
      checks++;
      if (((r4 & f4) | (r1 & f1)) !== 4'b0000) begin
        errors++;
        $display("FAIL random_strobe_overlap cycle %0d: rise&fall d4=%b d1=%b required 0000", n, r4 & f4, r1 & f1);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sw4   = '0;
    sw1   = '0;
    test_reset();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_min_param();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
